bcd_conv_sched: RTL and testbench

BCD_CONV_SCHED -- requirements
Module: bcd_conv_sched

---
 rtl/bcd_conv_sched.sv | 162 ++++++++++++++++
 tb/tb_bcd_conv_sched.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_conv_sched.sv
// Two-channel scheduler in front of one shared binary-to-BCD converter.
// Each channel keeps a pending flag and a one-deep buffer. A round-robin
// arbiter grants one channel at a time. A four-state FSM starts the
// converter, waits for its result, and allows one retry after a timeout.
//
// Handshake: reqN is a one-cycle strobe; valN is sampled on that same edge.
// conv_ena is a one-cycle start strobe. conv_din stays stable from grant
// until the FSM returns to IDLE. conv_rdy is honoured only in WAIT.
// doneN pulses for exactly one cycle, and bcdN already holds the new result
// during that cycle.
module bcd_conv_sched #(
    parameter int TIMEOUT = 63
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0,
    input  logic [7:0]  val0,
    input  logic        req1,
    input  logic [7:0]  val1,
    output logic        conv_ena,
    output logic [7:0]  conv_din,
    input  logic [3:0]  conv_fdig,
    input  logic [3:0]  conv_sdig,
    input  logic [3:0]  conv_tdig,
    input  logic        conv_rdy,
    output logic [11:0] bcd0,
    output logic [11:0] bcd1,
    output logic        done0,
    output logic        done1,
    output logic        busy,
    output logic        err,
    output logic [1:0]  dbg_state
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LOAD    = 2'd1,
        S_WAIT    = 2'd2,
        S_CAPTURE = 2'd3
    } state_t;

    state_t          state, state_nxt;
    logic            pend0, pend1;
    logic [7:0]      buf0, buf1;
    logic [CW-1:0]   wait_cnt;
    logic            retried;     // current request already had its retry
    logic            svc_ch;      // channel currently in service
    logic            rr_last;     // channel of the last completed conversion
    logic            rr_seen;     // a conversion has completed since reset
    logic            grant, grant_ch1, capture, retry_go, drop;
    logic            timeout_hit;

    // Channel 1 wins only when channel 0 is idle or when channel 0 was served last.
    assign grant_ch1   = pend1 && (!pend0 || (rr_seen && !rr_last));
    assign timeout_hit = (wait_cnt == CW'(TIMEOUT - 1));

    assign conv_ena  = (state == S_LOAD);
    assign busy      = (state != S_IDLE);
    assign done0     = (state == S_CAPTURE) && !svc_ch;
    assign done1     = (state == S_CAPTURE) &&  svc_ch;
    assign dbg_state = state;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state decode and the single-cycle control strobes.
    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        capture   = 1'b0;
        retry_go  = 1'b0;
        drop      = 1'b0;
        case (state)
            S_IDLE: begin
                if (pend0 || pend1) begin
                    grant     = 1'b1;
                    state_nxt = S_LOAD;
                end
            end
            S_LOAD: state_nxt = S_WAIT;
            S_WAIT: begin
                // A result arriving on the timeout cycle still counts.
                if (conv_rdy) begin
                    capture   = 1'b1;
                    state_nxt = S_CAPTURE;
                end else if (timeout_hit) begin
                    if (!retried) begin
                        retry_go  = 1'b1;
                        state_nxt = S_LOAD;
                    end else begin
                        drop      = 1'b1;
                        state_nxt = S_IDLE;
                    end
                end
            end
            S_CAPTURE: state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // Request capture. A new request overrides a grant on the same edge, so it is never lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend0 <= 1'b0;
            pend1 <= 1'b0;
            buf0  <= '0;
            buf1  <= '0;
        end else begin
            if (req0)                      pend0 <= 1'b1;
            else if (grant && !grant_ch1)  pend0 <= 1'b0;
            if (req1)                      pend1 <= 1'b1;
            else if (grant && grant_ch1)   pend1 <= 1'b0;
            if (req0) buf0 <= val0;
            if (req1) buf1 <= val1;
        end
    end

    // Operand, wait counter and retry bookkeeping for the request in service.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conv_din <= '0;
            svc_ch   <= 1'b0;
            wait_cnt <= '0;
            retried  <= 1'b0;
        end else begin
            if (grant) begin
                conv_din <= grant_ch1 ? buf1 : buf0;
                svc_ch   <= grant_ch1;
                retried  <= 1'b0;
            end
            if (retry_go) retried <= 1'b1;
            if (state == S_LOAD)      wait_cnt <= '0;
            else if (state == S_WAIT) wait_cnt <= wait_cnt + CW'(1);
        end
    end

    // Results, error flag and round-robin pointer.
    // The digits are latched on the conv_rdy edge, so bcdN is valid while doneN is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcd0    <= '0;
            bcd1    <= '0;
            err     <= 1'b0;
            rr_last <= 1'b0;
            rr_seen <= 1'b0;
        end else begin
            if (capture && !svc_ch) bcd0 <= {conv_tdig, conv_sdig, conv_fdig};
            if (capture &&  svc_ch) bcd1 <= {conv_tdig, conv_sdig, conv_fdig};
            if (drop) err <= 1'b1;
            if (state == S_CAPTURE) begin
                rr_last <= svc_ch;
                rr_seen <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bcd_conv_sched.sv
// Testbench for bcd_conv_sched. It includes a behavioural model of the
// shared converter, a directed vector table, hand-written corner-case
// sequences, and a randomised run with a scoreboard.
module tb_bcd_conv_sched;

    localparam int T = 63;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    initial forever #5 clk = ~clk;

    logic        rst_n;
    logic        req0, req1;
    logic [7:0]  val0, val1;
    logic        conv_ena;
    logic [7:0]  conv_din;
    logic [3:0]  conv_fdig, conv_sdig, conv_tdig;
    logic        conv_rdy;
    logic [11:0] bcd0, bcd1;
    logic        done0, done1, busy, err;
    logic [1:0]  dbg_state;

    bcd_conv_sched #(.TIMEOUT(T)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .val0(val0), .req1(req1), .val1(val1),
        .conv_ena(conv_ena), .conv_din(conv_din),
        .conv_fdig(conv_fdig), .conv_sdig(conv_sdig), .conv_tdig(conv_tdig),
        .conv_rdy(conv_rdy),
        .bcd0(bcd0), .bcd1(bcd1), .done0(done0), .done1(done1),
        .busy(busy), .err(err), .dbg_state(dbg_state)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [11:0] to_bcd(input logic [7:0] v);
        int h, t, u;
        h = v / 100;
        t = (v / 10) % 10;
        u = v % 10;
        return {h[3:0], t[3:0], u[3:0]};
    endfunction

    // ---------------- converter model ----------------
    // Starts on conv_ena and produces its result dly_cfg cycles after the start cycle.
    // A new start (retry) restarts it. Reset aborts it.
    int         dly_cfg  = 5;
    bit         rand_dly = 0;
    bit         spur     = 0;
    logic [7:0] op       = '0;
    int         cnt_m    = 0;
    bit         active   = 0;

    initial begin
        conv_rdy = 1'b0;
        {conv_tdig, conv_sdig, conv_fdig} = 12'h000;
        forever begin
            @(negedge clk);
            conv_rdy = 1'b0;
            if (!rst_n) begin
                active = 0;
                cnt_m  = 0;
            end else if (spur) begin
                spur     = 0;
                conv_rdy = 1'b1;
                {conv_tdig, conv_sdig, conv_fdig} = 12'h999;
            end else if (conv_ena) begin
                op     = conv_din;
                cnt_m  = rand_dly ? int'($urandom_range(1, 40)) : dly_cfg;
                active = 1;
            end else if (active) begin
                cnt_m--;
                if (cnt_m == 0) begin
                    active   = 0;
                    conv_rdy = 1'b1;
                    {conv_tdig, conv_sdig, conv_fdig} = to_bcd(op);
                end
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    int cyc = 0;
    always @(posedge clk) cyc++;

    int   ena_log[$];
    int   done0_cnt = 0, done1_cnt = 0;
    int   first_done_ch  = -1;
    int   first_done_cyc = -1;
    bit   rand_mode = 0;
    logic [7:0] exp_q0[$];
    logic [7:0] exp_q1[$];

    function automatic bit in_q(input logic [7:0] v, input bit ch);
        bit found;
        found = 0;
        if (!ch) begin
            foreach (exp_q0[i]) if (exp_q0[i] == v) found = 1;
        end else begin
            foreach (exp_q1[i]) if (exp_q1[i] == v) found = 1;
        end
        return found;
    endfunction

    initial begin
        forever begin
            @(negedge clk);
            if (conv_ena === 1'b1) ena_log.push_back(cyc);
            if (done0 === 1'b1) begin
                done0_cnt++;
                if (first_done_ch < 0) begin first_done_ch = 0; first_done_cyc = cyc; end
                chk("done0_bcd", 32'(bcd0), 32'(to_bcd(op)));
                if (rand_mode) chk("rand_member0", 32'(in_q(op, 1'b0)), 32'd1);
            end
            if (done1 === 1'b1) begin
                done1_cnt++;
                if (first_done_ch < 0) begin first_done_ch = 1; first_done_cyc = cyc; end
                chk("done1_bcd", 32'(bcd1), 32'(to_bcd(op)));
                if (rand_mode) chk("rand_member1", 32'(in_q(op, 1'b1)), 32'd1);
            end
        end
    end

    // ---------------- driver tasks ----------------
    int req_cyc = 0;

    task automatic clear_log();
        ena_log.delete();
        done0_cnt      = 0;
        done1_cnt      = 0;
        first_done_ch  = -1;
        first_done_cyc = -1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        req0 = 1'b0; req1 = 1'b0; val0 = '0; val1 = '0;
        spur = 0;
        repeat (2) @(negedge clk);
        chk("reset_outputs",
            32'({conv_ena, conv_din, bcd0, bcd1, done0, done1, busy, err, dbg_state}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        clear_log();
    endtask

    // Called at a negedge; drives one request cycle and returns at the next negedge.
    task automatic do_req(input bit r0, input logic [7:0] v0, input bit r1, input logic [7:0] v1);
        req0 = r0; val0 = v0; req1 = r1; val1 = v1;
        req_cyc = cyc;
        @(negedge clk);
        req0 = 1'b0; req1 = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int quiet;
        quiet = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!busy) quiet++; else quiet = 0;
            if (quiet >= 4) break;
        end
        chk("idle_reached", 32'(quiet >= 4), 32'd1);
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic [1:0]  mask;
        logic [7:0]  v0, v1;
        int          dly;
        logic [11:0] b0, b1;
        int          d0, d1;
        logic        er;
        int          enas;
        int          first;
    } vec_t;

    vec_t tbl[6];

    initial begin
        tbl[0] = '{2'b01, 8'd255, 8'd0,   18,    12'h255, 12'h000, 1, 0, 1'b0, 1, 0};
        tbl[1] = '{2'b11, 8'd37,  8'd200, 5,     12'h037, 12'h200, 1, 1, 1'b0, 2, 0};
        tbl[2] = '{2'b10, 8'd0,   8'd0,   1,     12'h000, 12'h000, 0, 1, 1'b0, 1, 1};
        tbl[3] = '{2'b01, 8'd99,  8'd0,   T,     12'h099, 12'h000, 1, 0, 1'b0, 1, 0};
        tbl[4] = '{2'b01, 8'd123, 8'd0,   T + 1, 12'h000, 12'h000, 0, 0, 1'b1, 2, -1};
        tbl[5] = '{2'b01, 8'd128, 8'd0,   200,   12'h000, 12'h000, 0, 0, 1'b1, 2, -1};

        rst_n = 1'b0;
        req0 = 1'b0; req1 = 1'b0; val0 = '0; val1 = '0;

        for (int i = 0; i < 6; i++) begin
            apply_reset();
            dly_cfg = tbl[i].dly;
            do_req(tbl[i].mask[0], tbl[i].v0, tbl[i].mask[1], tbl[i].v1);
            wait_idle(400);
            chk($sformatf("v%0d_bcd0", i), 32'(bcd0), 32'(tbl[i].b0));
            chk($sformatf("v%0d_bcd1", i), 32'(bcd1), 32'(tbl[i].b1));
            chk($sformatf("v%0d_done0", i), 32'(done0_cnt), 32'(tbl[i].d0));
            chk($sformatf("v%0d_done1", i), 32'(done1_cnt), 32'(tbl[i].d1));
            chk($sformatf("v%0d_err", i), 32'(err), 32'(tbl[i].er));
            chk($sformatf("v%0d_ena_cnt", i), 32'(ena_log.size()), 32'(tbl[i].enas));
            chk($sformatf("v%0d_first_ch", i), 32'(first_done_ch), 32'(tbl[i].first));
            chk($sformatf("v%0d_ena_latency", i),
                32'((ena_log.size() > 0) ? ena_log[0] - req_cyc : -1), 32'd2);
            if (tbl[i].d0 + tbl[i].d1 > 0)
                chk($sformatf("v%0d_done_latency", i),
                    32'(first_done_cyc - ena_log[0]), 32'(tbl[i].dly + 1));
            if (tbl[i].enas == 2 && tbl[i].er)
                chk($sformatf("v%0d_retry_gap", i), 32'(ena_log[1] - ena_log[0]), 32'(T + 1));
            if (tbl[i].d0 + tbl[i].d1 == 2)
                chk($sformatf("v%0d_b2b_gap", i), 32'(ena_log[1] - first_done_cyc), 32'd2);
        end

        // Overwrite while pending: ch0 is in service, ch1 receives two requests; only the newest is converted.
        apply_reset();
        dly_cfg = 20;
        do_req(1'b1, 8'd5, 1'b0, 8'd0);
        repeat (3) @(negedge clk);
        do_req(1'b0, 8'd0, 1'b1, 8'd10);
        do_req(1'b0, 8'd0, 1'b1, 8'd99);
        wait_idle(400);
        chk("ovr_done1_cnt", 32'(done1_cnt), 32'd1);
        chk("ovr_bcd1", 32'(bcd1), 32'h099);
        chk("ovr_bcd0", 32'(bcd0), 32'h005);
        chk("ovr_ena_cnt", 32'(ena_log.size()), 32'd2);

        // val0 wiggles while the conversion is running, with no new req0.
        apply_reset();
        dly_cfg = 15;
        do_req(1'b1, 8'd77, 1'b0, 8'd0);
        repeat (2) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            val0 = 8'($urandom);
            @(negedge clk);
            chk("din_hold", 32'(conv_din), 32'd77);
        end
        wait_idle(400);
        chk("hold_bcd0", 32'(bcd0), 32'h077);
        chk("hold_done0", 32'(done0_cnt), 32'd1);

        // Reset during WAIT, then a spurious conv_rdy.
        apply_reset();
        dly_cfg = 30;
        do_req(1'b1, 8'd200, 1'b0, 8'd0);
        repeat (6) @(negedge clk);
        chk("rst_pre_state", 32'(dbg_state), 32'd2);
        rst_n = 1'b0;
        #1;
        chk("rst_async",
            32'({conv_ena, conv_din, bcd0, bcd1, done0, done1, busy, err, dbg_state}), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        spur = 1;
        repeat (4) @(negedge clk);
        chk("spur_outputs",
            32'({conv_ena, conv_din, bcd0, bcd1, done0, done1, busy, err, dbg_state}), 32'd0);
        chk("spur_no_done", 32'(done0_cnt + done1_cnt), 32'd0);

        // Round-robin: after serving ch0, a simultaneous pair goes to ch1 first.
        apply_reset();
        dly_cfg = 3;
        do_req(1'b1, 8'd1, 1'b0, 8'd0);
        wait_idle(200);
        first_done_ch = -1;
        do_req(1'b1, 8'd2, 1'b1, 8'd3);
        wait_idle(200);
        chk("rr_first_a", 32'(first_done_ch), 32'd1);
        first_done_ch = -1;
        do_req(1'b1, 8'd4, 1'b1, 8'd5);
        wait_idle(200);
        chk("rr_first_b", 32'(first_done_ch), 32'd1);
        chk("rr_bcd0", 32'(bcd0), 32'h004);
        chk("rr_bcd1", 32'(bcd1), 32'h005);

        // Randomised traffic: every result must belong to its channel's request history,
        // and after draining, each channel must hold its newest request.
        begin
            logic [7:0] last0, last1;
            bit any0, any1;
            bit r0, r1;
            logic [7:0] v0, v1;
            any0 = 0; any1 = 0; last0 = '0; last1 = '0;
            apply_reset();
            exp_q0.delete();
            exp_q1.delete();
            rand_dly  = 1;
            rand_mode = 1;
            for (int c = 0; c < 3000; c++) begin
                r0 = ($urandom_range(0, 11) == 0);
                r1 = ($urandom_range(0, 11) == 0);
                v0 = 8'($urandom);
                v1 = 8'($urandom);
                if (r0) begin exp_q0.push_back(v0); last0 = v0; any0 = 1; end
                if (r1) begin exp_q1.push_back(v1); last1 = v1; any1 = 1; end
                do_req(r0, v0, r1, v1);
            end
            wait_idle(2000);
            rand_mode = 0;
            rand_dly  = 0;
            if (any0) chk("rand_final_bcd0", 32'(bcd0), 32'(to_bcd(last0)));
            if (any1) chk("rand_final_bcd1", 32'(bcd1), 32'(to_bcd(last1)));
            chk("rand_err", 32'(err), 32'd0);
            chk("rand_progress", 32'(done0_cnt > 0 && done1_cnt > 0), 32'(any0 && any1));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
